// File: rtl/pic_pkg.sv
// pic_pkg: shared constants for the programmable interrupt controller.
//   NUM_IRQ_DEFAULT      number of request lines in the default build
//   SPURIOUS_VEC_DEFAULT vector returned when nothing is eligible at intack
//   PIC_MASK/PEND/ISR/EOI register offsets within the bus window
//   PIC_BASE             base address of the window, for the top-level decoder
// Optional feature macro: PIC_NESTING_EN (in-service tracking and EOI).
package pic_pkg;
    localparam int          NUM_IRQ_DEFAULT      = 8;
    localparam logic [15:0] SPURIOUS_VEC_DEFAULT = 16'h0007;

    localparam logic [1:0]  PIC_MASK = 2'd0;
    localparam logic [1:0]  PIC_PEND = 2'd1;
    localparam logic [1:0]  PIC_ISR  = 2'd2;
    localparam logic [1:0]  PIC_EOI  = 2'd3;

    localparam logic [11:0] PIC_BASE = 12'hA00;
endpackage

// File: rtl/pic_if.sv
// pic_if: CPU-side connection of the interrupt controller.
//   sel/a/we/wdata/rdata  memory-mapped register access (rdata combinational)
//   intack/int_out/vector interrupt request and acknowledge handshake
// master = CPU / bus side, slave = controller.
interface pic_if;
    logic        sel;
    logic [1:0]  a;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        intack;
    logic        int_out;
    logic [15:0] vector;

    modport master (
        output sel, a, we, wdata, intack,
        input  rdata, int_out, vector
    );

    modport slave (
        input  sel, a, we, wdata, intack,
        output rdata, int_out, vector
    );
endinterface

// File: rtl/pic_prio_enc.sv
// pic_prio_enc: combinational priority encoder, index 0 highest priority.
//   req   N-bit request vector
//   valid any request bit set
//   idx   index of the lowest set bit (0 when valid=0)
module pic_prio_enc #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the lowest priority upward so the highest-priority hit wins.
    always_comb begin
        valid = |req;
        idx   = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? IW'(i) : idx;
        end
    end

endmodule

// File: rtl/pic_controller.sv
// pic_controller: 8-input programmable interrupt controller.
//   clk, reset  clock and synchronous active-high reset
//   irq         rising-edge sensitive device requests
//   bus         pic_if.slave: register window (MASK/PEND/ISR/EOI) plus
//               intack / int_out / vector handshake with the CPU
// Build option PIC_NESTING_EN: in-service register gating lower-priority
// requests, cleared through EOI writes. Without it ISR reads 0.
module pic_controller
    import pic_pkg::*;
#(
    parameter int          NUM_IRQ      = NUM_IRQ_DEFAULT,
    parameter logic [15:0] SPURIOUS_VEC = SPURIOUS_VEC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    pic_if.slave               bus
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_d_r, mask_r, pend_r, isr_s;
    logic [NUM_IRQ-1:0] edge_s, limit_s, elig_s, w1c_s, ack_clr_s;
    logic               intack_d_r;
    logic [IW-1:0]      vec_q_r, elig_idx_s, isr_idx_s;
    logic               elig_valid_s, isr_valid_s;
    logic               ack_first_s, commit_s, wr_s;
    logic [15:0]        vector_s, rdata_s;
    logic               unused_s;

`ifdef PIC_NESTING_EN
    logic [NUM_IRQ-1:0] isr_r;
    logic [NUM_IRQ-1:0] eoi_clr_s;
    assign isr_s = isr_r;
`else
    assign isr_s = {NUM_IRQ{1'b0}};
`endif

    assign edge_s      = irq & ~irq_d_r;
    assign wr_s        = bus.sel & bus.we;
    assign ack_first_s = bus.intack & ~intack_d_r;
    assign commit_s    = ack_first_s & elig_valid_s;
    assign unused_s    = ^bus.wdata[15:NUM_IRQ];

    pic_prio_enc #(.N(NUM_IRQ), .IW(IW)) u_isr_enc (
        .req   (isr_s),
        .valid (isr_valid_s),
        .idx   (isr_idx_s)
    );

    pic_prio_enc #(.N(NUM_IRQ), .IW(IW)) u_elig_enc (
        .req   (elig_s),
        .valid (elig_valid_s),
        .idx   (elig_idx_s)
    );

    // Priority ceiling: only levels strictly above the active service level pass.
    always_comb begin
        limit_s = {NUM_IRQ{1'b0}};
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!isr_valid_s) begin
                limit_s[i] = 1'b1;
            end else begin
                limit_s[i] = (i < int'(isr_idx_s));
            end
        end
    end

    assign elig_s      = pend_r & ~mask_r & limit_s;
    assign bus.int_out = elig_valid_s;

    // PEND clear sources: software W1C and the acknowledged level.
    always_comb begin
        w1c_s     = {NUM_IRQ{1'b0}};
        ack_clr_s = {NUM_IRQ{1'b0}};
        if (wr_s && (bus.a == PIC_PEND)) begin
            w1c_s = bus.wdata[NUM_IRQ-1:0];
        end else begin
            w1c_s = {NUM_IRQ{1'b0}};
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr_s[i] = commit_s && (i == int'(elig_idx_s));
        end
    end

    // Vector: live encoder result on the first intack cycle, latched index after.
    always_comb begin
        vector_s = SPURIOUS_VEC;
        if (!bus.intack) begin
            vector_s = SPURIOUS_VEC;
        end else if (ack_first_s) begin
            vector_s = elig_valid_s ? {{(16 - IW){1'b0}}, elig_idx_s} : SPURIOUS_VEC;
        end else begin
            vector_s = {{(16 - IW){1'b0}}, vec_q_r};
        end
    end

    assign bus.vector = vector_s;

    // Register read mux; EOI is write-only.
    always_comb begin
        rdata_s = 16'h0000;
        if (bus.sel) begin
            case (bus.a)
                PIC_MASK: rdata_s = {{(16 - NUM_IRQ){1'b0}}, mask_r};
                PIC_PEND: rdata_s = {{(16 - NUM_IRQ){1'b0}}, pend_r};
                PIC_ISR:  rdata_s = {{(16 - NUM_IRQ){1'b0}}, isr_s};
                default:  rdata_s = 16'h0000;
            endcase
        end else begin
            rdata_s = 16'h0000;
        end
    end

    assign bus.rdata = rdata_s;

    // Edge/acknowledge history, MASK, PEND (edge set beats any clear) and vec_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d_r    <= {NUM_IRQ{1'b0}};
            intack_d_r <= 1'b0;
            mask_r     <= {NUM_IRQ{1'b0}};
            pend_r     <= {NUM_IRQ{1'b0}};
            vec_q_r    <= {IW{1'b0}};
        end else begin
            irq_d_r    <= irq;
            intack_d_r <= bus.intack;
            if (wr_s && (bus.a == PIC_MASK)) begin
                mask_r <= bus.wdata[NUM_IRQ-1:0];
            end
            pend_r <= (pend_r & ~w1c_s & ~ack_clr_s) | edge_s;
            if (commit_s) begin
                vec_q_r <= elig_idx_s;
            end
        end
    end

`ifdef PIC_NESTING_EN
    // EOI target comes from the pre-commit ISR: specific index or highest level.
    always_comb begin
        eoi_clr_s = {NUM_IRQ{1'b0}};
        if (wr_s && (bus.a == PIC_EOI)) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (bus.wdata[3]) begin
                    eoi_clr_s[i] = (i == int'(bus.wdata[2:0]));
                end else begin
                    eoi_clr_s[i] = isr_valid_s && (i == int'(isr_idx_s));
                end
            end
        end else begin
            eoi_clr_s = {NUM_IRQ{1'b0}};
        end
    end

    // In-service register: EOI clears, acknowledge commit sets.
    always_ff @(posedge clk) begin
        if (reset) begin
            isr_r <= {NUM_IRQ{1'b0}};
        end else begin
            isr_r <= (isr_r & ~eoi_clr_s) | ack_clr_s;
        end
    end
`endif

endmodule

// File: tb/tb_pic_controller.sv
// tb_pic_controller: directed test-plan sequences followed by randomized
// traffic, all checked every cycle against a bit-level reference model of the
// controller's rules (pending/mask/in-service sets, first-eligible search).
module tb_pic_controller;
    import pic_pkg::*;

`ifdef PIC_NESTING_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq;

    pic_if bus();

    pic_controller #(.NUM_IRQ(8), .SPURIOUS_VEC(16'h0007)) dut (
        .clk   (clk),
        .reset (reset),
        .irq   (irq),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // reference model state
    bit [7:0] m_mask, m_pend, m_isr, m_irq_d;
    bit       m_ack_d;
    int       m_vecq;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_elig(input int i);
        if (!m_pend[i] || m_mask[i]) return 1'b0;
        if (NEST) begin
            for (int j = 0; j <= i; j++) begin
                if (m_isr[j]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic int m_first();
        for (int i = 0; i < 8; i++) begin
            if (m_elig(i)) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic r, input logic [7:0] q, input logic k,
                         input logic s, input logic [1:0] aa, input logic w,
                         input logic [15:0] d);
        reset      = r;
        irq        = q;
        bus.intack = k;
        bus.sel    = s;
        bus.a      = aa;
        bus.we     = w;
        bus.wdata  = d;
    endtask

    // compare combinational outputs with the model, mid-cycle
    task automatic settle();
        int          f;
        logic [15:0] ev, er;
        #1;
        f = m_first();
        if (!bus.intack)  ev = 16'h0007;
        else if (!m_ack_d) ev = (f >= 0) ? 16'(f) : 16'h0007;
        else              ev = 16'(m_vecq);
        if (!bus.sel)             er = 16'h0000;
        else if (bus.a == 2'd0)   er = {8'h00, m_mask};
        else if (bus.a == 2'd1)   er = {8'h00, m_pend};
        else if (bus.a == 2'd2)   er = {8'h00, m_isr};
        else                      er = 16'h0000;
        check_val("int_out", {15'd0, bus.int_out}, {15'd0, (f >= 0)});
        check_val("vector", bus.vector, ev);
        check_val("rdata", bus.rdata, er);
    endtask

    // clock edge: update the model from the rules, return at the falling edge
    task automatic advance();
        int       f;
        bit [7:0] np, nm, ni;
        bit       commit;
        @(posedge clk);
        f = m_first();
        if (reset) begin
            m_mask = 8'h00; m_pend = 8'h00; m_isr = 8'h00;
            m_irq_d = 8'h00; m_ack_d = 1'b0; m_vecq = 0;
        end else begin
            np = m_pend; nm = m_mask; ni = m_isr;
            commit = bus.intack && !m_ack_d && (f >= 0);
            if (bus.sel && bus.we) begin
                if (bus.a == 2'd0) nm = bus.wdata[7:0];
                if (bus.a == 2'd1) np = np & ~bus.wdata[7:0];
                if (bus.a == 2'd3 && NEST) begin
                    if (bus.wdata[3]) begin
                        ni[bus.wdata[2:0]] = 1'b0;
                    end else begin
                        for (int j = 0; j < 8; j++) begin
                            if (ni[j]) begin
                                ni[j] = 1'b0;
                                break;
                            end
                        end
                    end
                end
            end
            if (commit) begin
                np[f] = 1'b0;
                if (NEST) ni[f] = 1'b1;
                m_vecq = f;
            end
            np = np | (irq & ~m_irq_d);
            m_pend = np; m_mask = nm; m_isr = ni;
            m_irq_d = irq;
            m_ack_d = bus.intack;
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic r, input logic [7:0] q, input logic k,
                       input logic s, input logic [1:0] aa, input logic w,
                       input logic [15:0] d);
        drive(r, q, k, s, aa, w, d);
        settle();
        advance();
    endtask

    initial begin
        int          ack_left;
        logic        r_r, k_r, s_r, w_r;
        logic [7:0]  q_r;
        logic [1:0]  a_r;
        logic [15:0] d_r;

        m_mask = 8'h00; m_pend = 8'h00; m_isr = 8'h00;
        m_irq_d = 8'h00; m_ack_d = 1'b0; m_vecq = 0;

        @(negedge clk);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        advance();
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);

        // reset state
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000);
        settle();
        check_val("rst_int", {15'd0, bus.int_out}, 16'h0000);
        check_val("rst_vec", bus.vector, 16'h0007);
        advance();

        // basic request and acknowledge of irq[2]
        cyc(1'b0, 8'h04, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000);
        settle();
        check_val("tp1_pend", bus.rdata, 16'h0004);
        check_val("tp1_int", {15'd0, bus.int_out}, 16'h0001);
        advance();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000);
        settle();
        check_val("tp1_vec", bus.vector, 16'h0002);
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000);
        settle();
        check_val("tp1_isr", bus.rdata, NEST ? 16'h0004 : 16'h0000);
        check_val("tp1_int0", {15'd0, bus.int_out}, 16'h0000);
        advance();

        // nesting: lower level blocked, higher level preempts, EOIs unwind
        cyc(1'b0, 8'h20, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        settle();
        check_val("nest_irq5_int", {15'd0, bus.int_out}, NEST ? 16'h0000 : 16'h0001);
        advance();
        cyc(1'b0, 8'h02, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000);
        settle();
        check_val("nest_vec1", bus.vector, 16'h0001);
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000);
        settle();
        check_val("nest_isr6", bus.rdata, NEST ? 16'h0006 : 16'h0000);
        advance();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b1, 16'h0000);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000);
        settle();
        check_val("nest_isr4", bus.rdata, NEST ? 16'h0004 : 16'h0000);
        advance();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b1, 16'h0000);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 16'h0000);
        settle();
        check_val("nest_isr0", bus.rdata, 16'h0000);
        check_val("nest_int5", {15'd0, bus.int_out}, 16'h0001);
        advance();

        // mask gating
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 16'h0004);
        cyc(1'b0, 8'h04, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000);
        settle();
        check_val("mask_pend", bus.rdata, 16'h0004);
        check_val("mask_int0", {15'd0, bus.int_out}, 16'h0000);
        advance();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 16'h0000);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        settle();
        check_val("mask_int1", {15'd0, bus.int_out}, 16'h0001);
        advance();

        // simultaneous irq0/irq3 with intack held three cycles
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b0, 8'h09, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000);
            settle();
            check_val("hold_vec", bus.vector, 16'h0000);
            advance();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000);
        settle();
        check_val("hold_pend", bus.rdata, 16'h0008);
        advance();

        // spurious acknowledge, then W1C racing an edge on the same bit
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0000);
        settle();
        check_val("spur_vec", bus.vector, 16'h0007);
        advance();
        cyc(1'b0, 8'h08, 1'b0, 1'b1, 2'd1, 1'b1, 16'h0008);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000);
        settle();
        check_val("w1c_race", bus.rdata, 16'h0008);
        advance();

        // reset in the middle of service
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b0, 8'h02, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b0, 8'h10, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 2'(i), 1'b0, 16'h0000);
            settle();
            check_val("midrst_reg", bus.rdata, 16'h0000);
            check_val("midrst_int", {15'd0, bus.int_out}, 16'h0000);
            advance();
        end

        // irq held high across reset release counts as an edge
        cyc(1'b1, 8'h40, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        cyc(1'b0, 8'h40, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
        drive(1'b0, 8'h40, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000);
        settle();
        check_val("rel_pend", bus.rdata, 16'h0040);
        check_val("rel_int", {15'd0, bus.int_out}, 16'h0001);
        advance();

        // randomized traffic
        ack_left = 0;
        for (int n = 0; n < 3000; n++) begin
            r_r = ($urandom_range(0, 299) == 0);
            q_r = 8'($urandom & $urandom & $urandom);
            if (ack_left > 0) begin
                k_r = 1'b1;
                ack_left--;
            end else if ($urandom_range(0, 5) == 0) begin
                k_r = 1'b1;
                ack_left = $urandom_range(0, 2);
            end else begin
                k_r = 1'b0;
            end
            s_r = $urandom_range(0, 1) == 1;
            w_r = $urandom_range(0, 3) == 0;
            a_r = 2'($urandom_range(0, 3));
            d_r = 16'($urandom);
            if (a_r == 2'd0) d_r = d_r & 16'($urandom);
            cyc(r_r, q_r, k_r, s_r, a_r, w_r, d_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/pic_controller.md
# pic_controller

Programmable 8-input interrupt controller that sits between the peripheral IRQ lines (e.g. the interrupt-driven button) and the mammal CPU's `INT`/`intack` pins, replacing the fixed combinational priority encoder in the top level. It latches IRQ rising edges into a pending register, applies a CPU-writable mask, tracks in-service levels for nested priority, and answers the CPU's `intack` cycle with the vector number. It also exposes its registers on the memory-mapped bus at the 0xA00–0xA03 window; the top-level decode drives `sel`.

## Interface
Parameters:
- `NUM_IRQ`, 8, number of request lines; index 0 is highest priority.
- `SPURIOUS_VEC`, 16'h0007, vector returned on an `intack` with nothing eligible.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `irq` in NUM_IRQ: device requests, rising-edge sensitive.
- `intack` in 1: CPU interrupt acknowledge.
- `int_out` out 1: interrupt request to the CPU `INT` pin.
- `vector` out 16: vector number, valid while `intack`=1.
- `sel` in 1: address falls in the PIC window (decoded by the top level).
- `a` in 2: register offset (`address[1:0]`).
- `we` in 1: write strobe (`memwt`).
- `wdata` in 16: CPU `data_out`.
- `rdata` out 16: register read data, combinational; 0 when `sel`=0.

## Operation
- Registers at offset `a`; unused upper bits read as 0.
  - 0 MASK: read/write, bits[7:0]. 1 = masked.
  - 1 PEND: read; a write of 1 to a bit clears that bit (W1C).
  - 2 ISR: read-only.
  - 3 EOI: write-only; reads return 0.
- Edge detect: `irq_d` holds `irq` delayed one clock. On `irq & ~irq_d`, the matching PEND bit is set.
- Eligible set: `PEND & ~MASK`, limited to bits of higher priority than the highest set ISR bit.
- `int_out` = eligible set is non-empty. It is combinational from the registers and does not depend on `irq` directly.
- Acknowledge commit, on the first `intack` cycle (`intack & ~intack_d`):
  - `vector` = index of the highest-priority eligible bit, zero-extended to 16 bits.
  - At the closing clock edge, that PEND bit is cleared, that ISR bit is set, and the index is stored in `vec_q`.
  - While `intack` stays high after the first cycle, `vector` = `vec_q` and no further commit occurs.
- Spurious acknowledge (eligible set empty): `vector` = SPURIOUS_VEC and no state changes.
- EOI write:
  - `wdata[3]`=0 (non-specific): clears the highest-priority set ISR bit.
  - `wdata[3]`=1 (specific): clears `ISR[wdata[2:0]]`.
  - A non-specific EOI with ISR=0 has no effect.
- Simultaneous events:
  - An edge-set and a W1C on the same PEND bit in the same cycle: set wins.
  - An `intack` commit and an EOI in the same cycle: both apply; the EOI selects its bit from the pre-commit ISR.
  - A new edge on a bit that is already pending is lost (no count is kept).
- Reset values: MASK=0x00, PEND=0, ISR=0, `irq_d`=0, `intack_d`=0, `vec_q`=0.
  - Resulting outputs: `int_out`=0, `vector`=SPURIOUS_VEC, `rdata`=0.
  - A reset in the middle of an acknowledge or service sequence abandons it. An `irq` line still high when reset is released is seen as an edge on the first cycle after reset.

## Timing
- `irq` rises before edge N → PEND set at edge N → `int_out` high in cycle N+1.
- Register writes take effect at the clock edge; reads are same-cycle combinational.
- Acknowledge: `vector` is valid combinationally in the first `intack` cycle. State updates at the end of that cycle, so `int_out` re-evaluates in the next cycle.
- Following an EOI write, `int_out` may reassert one cycle after the write edge.

## Configuration
- `PIC_NESTING_EN` defined:
  - ISR is tracked and gates lower-priority requests.
  - EOI behaves as described above.
- `PIC_NESTING_EN` undefined:
  - No ISR flops; ISR reads 0 and EOI writes are ignored.
  - Eligible set = `PEND & ~MASK`.
  - An acknowledge only clears PEND.

## Structure
- `pic_pkg` holds:
  - `NUM_IRQ_DEFAULT`.
  - Register offset constants `PIC_MASK`, `PIC_PEND`, `PIC_ISR`, `PIC_EOI`.
  - `SPURIOUS_VEC_DEFAULT`.
  - The base address constant `PIC_BASE = 12'hA00` used by the top-level decoder.
- Sub-module `pic_prio_enc`: combinational NUM_IRQ-bit priority encoder (output `valid` plus index). It is instantiated twice: once for the eligible set and once for the highest ISR bit.

## Test plan
- Reset, then pulse `irq[2]` for 1 cycle → PEND=0x04 and `int_out`=1 one cycle later. `intack` for 1 cycle → `vector`=0x0002, then PEND=0, ISR=0x04, `int_out`=0.
- MASK=0x04, then pulse `irq[2]` → PEND=0x04, `int_out`=0. Write MASK=0 → `int_out`=1 the next cycle.
- Nesting (macro defined): ISR=0x04 pending service. Pulse `irq[5]` → `int_out` stays 0. Pulse `irq[1]` → `int_out`=1 and `intack` gives `vector`=1, ISR=0x06. Non-specific EOI → ISR=0x04. Second EOI → ISR=0 and `int_out`=1 for irq5.
- `irq[0]` and `irq[3]` rise in the same cycle, then `intack` held 3 cycles → `vector`=0x0000 in all 3 cycles; PEND=0x08 afterwards.
- Spurious: `intack` with PEND=0 → `vector`=0x0007 and no register changes. A W1C write of 0x08 on the same cycle as an `irq[3]` edge → PEND bit 3 remains 1.
- Assert `reset` while ISR=0x02 and PEND=0x10 → all registers 0 and `int_out`=0 on the next cycle.
